// File: rtl/npc_mc.sv
// npc_mc: multi-cycle RV32I/E subset core (FETCH/EXEC/WB/HALT).
// Optional macro NPC_EBREAK_HALT_EN: ebreak halts instead of acting as a nop.
module npc_mc #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          NR_REGS  = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_inst,
    output logic [31:0] pc,
    output logic [31:0] alu_result,
    output logic        commit,
    output logic [31:0] commit_pc,
    output logic        halt,
    output logic        illegal
);

    localparam int AW = (NR_REGS == 16) ? 4 : 5;

`ifdef NPC_EBREAK_HALT_EN
    localparam logic EBRK_HALT = 1'b1;
`else
    localparam logic EBRK_HALT = 1'b0;
`endif

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_WB    = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]    state;
    logic [31:0]   inst;
    logic [31:0]   next_pc;
    logic          wb_en;
    logic [AW-1:0] wb_rd;
    logic [31:0]   regs [NR_REGS];

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rv1;
    logic [31:0] rv2;
    logic [31:0] seq_pc;

    logic is_addi, is_add, is_lui, is_auipc;
    logic is_jal, is_jalr, is_ebrk;
    logic use_rs1, use_rs2, use_rd;
    logic bad_reg, bad_tgt, ill, ebrk_halt;
    logic [31:0] res;
    logic [31:0] tgt;

    assign imem_req  = (state == S_FETCH) && !rst;
    assign imem_addr = pc;
    assign commit    = (state == S_WB);
    assign halt      = (state == S_HALT);

    assign opc   = inst[6:0];
    assign rd    = inst[11:7];
    assign f3    = inst[14:12];
    assign rs1   = inst[19:15];
    assign rs2   = inst[24:20];
    assign f7    = inst[31:25];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20],
                    inst[30:21], 1'b0};

    assign rv1    = (rs1 == 5'd0) ? 32'd0 : regs[rs1[AW-1:0]];
    assign rv2    = (rs2 == 5'd0) ? 32'd0 : regs[rs2[AW-1:0]];
    assign seq_pc = pc + 32'd4;

    assign is_addi  = (opc == 7'b0010011) && (f3 == 3'b000);
    assign is_add   = (opc == 7'b0110011) && (f3 == 3'b000)
                   && (f7 == 7'b0000000);
    assign is_lui   = (opc == 7'b0110111);
    assign is_auipc = (opc == 7'b0010111);
    assign is_jal   = (opc == 7'b1101111);
    assign is_jalr  = (opc == 7'b1100111) && (f3 == 3'b000);
    assign is_ebrk  = (inst == 32'h0010_0073);

    // Decode and execute the latched instruction
    always_comb begin
        res     = alu_result;
        tgt     = seq_pc;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        ill     = 1'b0;
        unique case (1'b1)
            is_addi: begin
                res = rv1 + imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
            end
            is_add: begin
                res = rv1 + rv2; use_rs1 = 1'b1;
                use_rs2 = 1'b1; use_rd = 1'b1;
            end
            is_lui: begin
                res = imm_u; use_rd = 1'b1;
            end
            is_auipc: begin
                res = pc + imm_u; use_rd = 1'b1;
            end
            is_jal: begin
                res = seq_pc; tgt = pc + imm_j; use_rd = 1'b1;
            end
            is_jalr: begin
                res = seq_pc; tgt = (rv1 + imm_i) & ~32'd1;
                use_rs1 = 1'b1; use_rd = 1'b1;
            end
            is_ebrk: begin
                res = alu_result;
            end
            default: ill = 1'b1;
        endcase
    end

    assign bad_reg = (NR_REGS == 16)
                  && ((use_rd && rd[4]) || (use_rs1 && rs1[4])
                   || (use_rs2 && rs2[4]));
    assign bad_tgt   = (is_jal || is_jalr) && tgt[1];
    assign ebrk_halt = is_ebrk && EBRK_HALT;

    // Instruction sequencer: fetch, execute, write back, halt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            inst       <= '0;
            next_pc    <= RESET_PC;
            alu_result <= '0;
            commit_pc  <= '0;
            illegal    <= 1'b0;
            wb_en      <= 1'b0;
            wb_rd      <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        inst  <= imem_inst;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ill || bad_reg || bad_tgt) begin
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end else if (ebrk_halt) begin
                        state <= S_HALT;
                    end else begin
                        alu_result <= res;
                        next_pc    <= tgt;
                        commit_pc  <= pc;
                        wb_en      <= use_rd && (rd != 5'd0);
                        wb_rd      <= rd[AW-1:0];
                        state      <= S_WB;
                    end
                end
                S_WB: begin
                    pc    <= next_pc;
                    state <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Register file: cleared on reset, written only in WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_REGS; i++) regs[i] <= '0;
        end else if (state == S_WB && wb_en) begin
            regs[wb_rd] <= alu_result;
        end
    end

endmodule

// File: tb/tb_npc_mc.sv
// tb_npc_mc: directed program with a commit scoreboard for npc_mc.
// Driver pushes expected retirements; a monitor pops them on commit.
module tb_npc_mc;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        bit          chk_res;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_inst = '0;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        commit;
    logic [31:0] commit_pc;
    logic        halt;
    logic        illegal;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    npc_mc #(.RESET_PC(RST_PC), .NR_REGS(16)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_inst(imem_inst),
        .pc(pc), .alu_result(alu_result),
        .commit(commit), .commit_pc(commit_pc),
        .halt(halt), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every commit must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && commit) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", commit_pc, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("commit_pc", commit_pc, e.pc);
                if (e.chk_res) chk("alu_result", alu_result, e.res);
                chk("commit_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_pc", pc, RST_PC);
        end
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_alu", alu_result, 32'd0);
        chk("rst_cpc", commit_pc, 32'd0);
        chk("rst_flags", {29'd0, commit, halt, illegal}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ins,
                         input int dly, input bit push, input bit cr,
                         input logic [31:0] res, input bit hold);
        int n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            chk("req_timeout", 32'd0, 32'd1);
            return;
        end
        chk("imem_addr", imem_addr, a);
        for (int i = 0; i < dly; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            chk("stall_addr", imem_addr, a);
            chk("stall_commit", {31'd0, commit}, 32'd0);
        end
        imem_ack  = 1'b1;
        imem_inst = ins;
        if (push) sb.push_back('{a, res, cr, cyc + 2});
        @(negedge clk);
        if (hold) begin
            imem_inst = 32'hffff_ffff;
            @(negedge clk);
            @(negedge clk);
        end
        imem_ack  = 1'b0;
        imem_inst = '0;
    endtask

    task automatic expect_halt(input logic exp_ill);
        @(negedge clk);
        chk("halt", {31'd0, halt}, 32'd1);
        chk("illegal", {31'd0, illegal}, {31'd0, exp_ill});
        imem_ack  = 1'b1;
        imem_inst = 32'h0050_0093;
        repeat (3) @(negedge clk);
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_sticky", {30'd0, halt, illegal}, {30'd0, 1'b1, exp_ill});
        imem_ack  = 1'b0;
        imem_inst = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        fetch(32'h8000_0000, 32'h0050_0093, 0, 1, 1, 32'h0000_0005, 0);
        fetch(32'h8000_0004, 32'h0010_8133, 0, 1, 1, 32'h0000_000a, 0);
        fetch(32'h8000_0008, 32'h0080_00ef, 4, 1, 1, 32'h8000_000c, 0);
        fetch(32'h8000_0010, 32'h0000_8233, 0, 1, 1, 32'h8000_000c, 1);
        fetch(32'h8000_0014, 32'h0070_0013, 0, 1, 1, 32'h0000_0007, 0);
        fetch(32'h8000_0018, 32'h0000_01b3, 0, 1, 1, 32'h0000_0000, 0);
        fetch(32'h8000_001c, 32'h1234_52b7, 1, 1, 1, 32'h1234_5000, 0);
        fetch(32'h8000_0020, 32'h0000_1317, 0, 1, 1, 32'h8000_1020, 0);
        fetch(32'h8000_0024, 32'h0182_03e7, 0, 1, 1, 32'h8000_0028, 0);
        fetch(32'h8000_0024, 32'hfff0_0413, 0, 1, 1, 32'hffff_ffff, 0);
        fetch(32'h8000_0028, 32'h0054_04b3, 2, 1, 1, 32'h1234_4fff, 0);
`ifdef NPC_EBREAK_HALT_EN
        fetch(32'h8000_002c, 32'h0010_0073, 0, 0, 0, 32'h0, 0);
        expect_halt(1'b0);
`else
        fetch(32'h8000_002c, 32'h0010_0073, 0, 1, 0, 32'h0, 0);
        fetch(32'h8000_0030, 32'h0010_0513, 0, 1, 1, 32'h0000_0001, 0);
        repeat (3) @(negedge clk);
        chk("ebrk_nohalt", {31'd0, halt}, 32'd0);
`endif
        do_reset();
        fetch(32'h8000_0000, 32'h0020_8333, 0, 1, 1, 32'h0000_0000, 0);
        fetch(32'h8000_0004, 32'h0060_006f, 0, 0, 0, 32'h0, 0);
        expect_halt(1'b1);
        do_reset();
        fetch(32'h8000_0000, 32'h0050_0813, 0, 0, 0, 32'h0, 0);
        expect_halt(1'b1);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
